// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: 2-flop input synchroniser, false-start
// rejection, optional parity, variable stop length and framing/parity/break flags.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OS_TICK    = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    localparam int SMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OS_TICK / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS_TICK - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          PE     = (PARITY_EN != 0);
    localparam logic          ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] shift_q;
    logic            acc_q;
    logic            par_bad_q;
    logic            par_bit_q;
    logic            stop_q;
    logic            done_q;
    logic [DBIT-1:0] dout_q;
    logic            perr_q;
    logic            ferr_q;
    logic            brk_q;
    logic            stop_d;
    logic            brk_d;

    assign rx_s = sync_q[1];

    // When the stop period equals one bit, the stop sample and frame completion share a tick.
    assign stop_d = (s_q == S_BIT) ? rx_s : stop_q;
    assign brk_d  = (shift_q == '0) && !(PE && par_bit_q) && !stop_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            s_q       <= '0;
            n_q       <= '0;
            shift_q   <= '0;
            acc_q     <= 1'b0;
            par_bad_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_HALF) begin
                            if (rx_s) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                                acc_q   <= 1'b0;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_BIT) begin
                            shift_q <= {rx_s, shift_q[DBIT-1:1]};
                            acc_q   <= acc_q ^ rx_s;
                            s_q     <= '0;
                            if (n_q == N_LAST) begin
                                state_q <= PE ? PARITY : STOP;
                            end else begin
                                n_q <= n_q + NW'(1);
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_BIT) begin
                            par_bit_q <= rx_s;
                            par_bad_q <= acc_q ^ rx_s ^ ODD;
                            s_q       <= '0;
                            state_q   <= STOP;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == S_BIT) begin
                            stop_q <= rx_s;
                        end
                        if (s_q == S_STOP) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            dout_q  <= shift_q;
                            perr_q  <= PE ? par_bad_q : 1'b0;
                            ferr_q  <= !stop_d;
                            brk_q   <= brk_d;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign break_det    = brk_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 5N2) driven with
// table vectors plus hand sequences for glitch, break, mid-frame reset and back-to-back frames.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       rxA, rxB, rxC;
    logic       doneA, doneB, doneC;
    logic [7:0] doutA, doutB;
    logic [4:0] doutC;
    logic       perrA, perrB, perrC;
    logic       ferrA, ferrB, ferrC;
    logic       brkA, brkB, brkC;
    logic       busyA, busyB, busyC;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tickPhase = 0;
    int curDiv = 1;

    typedef struct {
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
        int         cyc;
    } cap_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       parBit;
        logic       stopVal;
        int         div;
        logic [8:0] expDout;
        logic       expPar;
        logic       expFrame;
        logic       expBreak;
        int         expLat;
    } vec_t;

    cap_t qA[$];
    cap_t qB[$];
    cap_t qC[$];
    vec_t vecs[15];

    uart_rx_cfg #(.DBIT(8)) dutA (
        .clk(clk), .reset_n(reset_n), .rx(rxA), .s_tick(s_tick),
        .rx_done_tick(doneA), .dout(doutA), .parity_err(perrA),
        .frame_err(ferrA), .break_det(brkA), .busy(busyA)
    );

    uart_rx_cfg #(.DBIT(8), .PARITY_EN(1), .PARITY_ODD(0)) dutB (
        .clk(clk), .reset_n(reset_n), .rx(rxB), .s_tick(s_tick),
        .rx_done_tick(doneB), .dout(doutB), .parity_err(perrB),
        .frame_err(ferrB), .break_det(brkB), .busy(busyB)
    );

    uart_rx_cfg #(.DBIT(5), .SB_TICK(32)) dutC (
        .clk(clk), .reset_n(reset_n), .rx(rxC), .s_tick(s_tick),
        .rx_done_tick(doneC), .dout(doutC), .parity_err(perrC),
        .frame_err(ferrC), .break_det(brkC), .busy(busyC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic cap_t mkCap(logic [8:0] d, logic p, logic f, logic b, int c);
        cap_t r;
        r.d = d; r.p = p; r.f = f; r.b = b; r.cyc = c;
        return r;
    endfunction

    // Every completed frame is logged per instance together with the cycle it appeared in.
    always @(negedge clk) begin
        if (doneA) qA.push_back(mkCap({1'b0, doutA}, perrA, ferrA, brkA, cyc));
        if (doneB) qB.push_back(mkCap({1'b0, doutB}, perrB, ferrB, brkB, cyc));
        if (doneC) qC.push_back(mkCap({4'b0, doutC}, perrC, ferrC, brkC, cyc));
    end

    function automatic vec_t mkVec(int inst, logic [8:0] data, logic parBit, logic stopVal,
                                   int div, logic [8:0] expDout, logic expPar,
                                   logic expFrame, logic expBreak, int expLat);
        vec_t v;
        v.inst = inst; v.data = data; v.parBit = parBit; v.stopVal = stopVal;
        v.div = div; v.expDout = expDout; v.expPar = expPar;
        v.expFrame = expFrame; v.expBreak = expBreak; v.expLat = expLat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic holdLine(input int inst, input logic val, input int nclk, output int firstCyc);
        firstCyc = 0;
        for (int i = 0; i < nclk; i++) begin
            @(negedge clk);
            if (i == 0) firstCyc = cyc;
            case (inst)
                0:       rxA = val;
                1:       rxB = val;
                default: rxC = val;
            endcase
            s_tick    = (tickPhase == 0);
            tickPhase = (tickPhase + 1) % curDiv;
        end
    endtask

    task automatic sendFrame(input int inst, input logic [8:0] data, input logic parBit,
                             input logic stopVal, output int fallCyc);
        int   dbit;
        int   nb;
        int   fc;
        logic val;
        dbit = (inst == 2) ? 5 : 8;
        nb   = 1 + dbit + ((inst == 1) ? 1 : 0) + ((inst == 2) ? 2 : 1);
        fallCyc = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                       val = 1'b0;
            else if (b <= dbit)               val = data[b-1];
            else if (inst == 1 && b == dbit + 1) val = parBit;
            else                              val = stopVal;
            holdLine(inst, val, 16 * curDiv, fc);
            if (b == 0) fallCyc = fc;
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int fallCyc);
        int fc;
        curDiv    = v.div;
        tickPhase = 0;
        sendFrame(v.inst, v.data, v.parBit, v.stopVal, fallCyc);
        holdLine(v.inst, 1'b1, 32 * curDiv, fc);
        curDiv    = 1;
        tickPhase = 0;
    endtask

    task automatic takeQueue(input int inst, output cap_t got[$], output logic busyNow);
        case (inst)
            0:       begin got = qA; qA.delete(); busyNow = busyA; end
            1:       begin got = qB; qB.delete(); busyNow = busyB; end
            default: begin got = qC; qC.delete(); busyNow = busyC; end
        endcase
    endtask

    task automatic checkOutput(input int idx, input vec_t v, input int fallCyc);
        cap_t got[$];
        logic busyNow;
        takeQueue(v.inst, got, busyNow);
        chk($sformatf("v%0d pulses", idx), got.size(), 1);
        chk($sformatf("v%0d busy", idx), {31'b0, busyNow}, 0);
        if (got.size() > 0) begin
            chk($sformatf("v%0d dout", idx), {23'b0, got[0].d}, {23'b0, v.expDout});
            chk($sformatf("v%0d parity_err", idx), {31'b0, got[0].p}, {31'b0, v.expPar});
            chk($sformatf("v%0d frame_err", idx), {31'b0, got[0].f}, {31'b0, v.expFrame});
            chk($sformatf("v%0d break_det", idx), {31'b0, got[0].b}, {31'b0, v.expBreak});
            if (v.expLat != 0)
                chk($sformatf("v%0d latency", idx), got[0].cyc - fallCyc, v.expLat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   fc;
        cap_t got[$];
        logic busyNow;

        vecs[0]  = mkVec(0, 9'h0A5, 0, 1, 1, 9'h0A5, 0, 0, 0, 155);
        vecs[1]  = mkVec(0, 9'h03C, 0, 0, 1, 9'h03C, 0, 1, 0, 0);
        vecs[2]  = mkVec(0, 9'h000, 0, 1, 1, 9'h000, 0, 0, 0, 0);
        vecs[3]  = mkVec(0, 9'h000, 0, 0, 1, 9'h000, 0, 1, 1, 0);
        vecs[4]  = mkVec(0, 9'h069, 0, 1, 2, 9'h069, 0, 0, 0, 0);
        vecs[5]  = mkVec(0, 9'h0FF, 0, 1, 1, 9'h0FF, 0, 0, 0, 0);
        vecs[6]  = mkVec(1, 9'h007, 1, 1, 1, 9'h007, 0, 0, 0, 171);
        vecs[7]  = mkVec(1, 9'h007, 0, 1, 1, 9'h007, 1, 0, 0, 0);
        vecs[8]  = mkVec(1, 9'h000, 0, 0, 1, 9'h000, 0, 1, 1, 0);
        vecs[9]  = mkVec(1, 9'h000, 1, 0, 1, 9'h000, 1, 1, 0, 0);
        vecs[10] = mkVec(1, 9'h080, 0, 1, 1, 9'h080, 1, 0, 0, 0);
        vecs[11] = mkVec(1, 9'h081, 0, 1, 1, 9'h081, 0, 0, 0, 0);
        vecs[12] = mkVec(2, 9'h015, 0, 1, 1, 9'h015, 0, 0, 0, 123);
        vecs[13] = mkVec(2, 9'h00A, 0, 1, 1, 9'h00A, 0, 0, 0, 0);
        vecs[14] = mkVec(2, 9'h01F, 0, 0, 1, 9'h01F, 0, 1, 0, 0);

        reset_n = 1'b0;
        rxA = 1'b1; rxB = 1'b1; rxC = 1'b1;
        s_tick = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dout", {24'b0, doutA}, 0);
        chk("reset flags", {28'b0, doneA, perrA, ferrA, brkA}, 0);
        chk("reset busy", {29'b0, busyA, busyB, busyC}, 0);
        reset_n = 1'b1;
        holdLine(0, 1'b1, 8, fc);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], fc);
            checkOutput(i, vecs[i], fc);
        end

        // A three-tick low pulse must be rejected without touching the last frame's results.
        holdLine(0, 1'b0, 3, fc);
        holdLine(0, 1'b1, 2, fc);
        chk("glitch busy high", {31'b0, busyA}, 1);
        holdLine(0, 1'b1, 40, fc);
        takeQueue(0, got, busyNow);
        chk("glitch pulses", got.size(), 0);
        chk("glitch busy low", {31'b0, busyNow}, 0);
        chk("glitch dout held", {24'b0, doutA}, 32'h0FF);

        // Twelve bit times low: a break frame, then an immediate restart that sees 0xFE.
        holdLine(0, 1'b0, 192, fc);
        holdLine(0, 1'b1, 200, fc);
        takeQueue(0, got, busyNow);
        chk("break pulses", got.size(), 2);
        if (got.size() == 2) begin
            chk("break dout", {23'b0, got[0].d}, 0);
            chk("break frame_err", {31'b0, got[0].f}, 1);
            chk("break break_det", {31'b0, got[0].b}, 1);
            chk("restart dout", {23'b0, got[1].d}, 32'h0FE);
            chk("restart flags", {29'b0, got[1].p, got[1].f, got[1].b}, 0);
        end

        fork
            begin
                sendFrame(0, 9'h0FF, 1'b0, 1'b1, fc);
                holdLine(0, 1'b1, 32, fc);
            end
            begin
                repeat (88) @(negedge clk);
                chk("pre-reset busy", {31'b0, busyA}, 1);
                #1 reset_n = 1'b0;
                #1;
                chk("midreset dout", {24'b0, doutA}, 0);
                chk("midreset state", {28'b0, busyA, doneA, ferrA, brkA}, 0);
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        takeQueue(0, got, busyNow);
        chk("midreset pulses", got.size(), 0);
        applyStimulus(mkVec(0, 9'h05A, 0, 1, 1, 9'h05A, 0, 0, 0, 0), fc);
        checkOutput(100, mkVec(0, 9'h05A, 0, 1, 1, 9'h05A, 0, 0, 0, 0), fc);

        // Two 5N2 frames with no idle gap between them.
        sendFrame(2, 9'h01F, 1'b0, 1'b1, fc);
        sendFrame(2, 9'h001, 1'b0, 1'b1, fc);
        holdLine(2, 1'b1, 32, fc);
        takeQueue(2, got, busyNow);
        chk("b2b pulses", got.size(), 2);
        if (got.size() == 2) begin
            chk("b2b first dout", {23'b0, got[0].d}, 32'h01F);
            chk("b2b second dout", {23'b0, got[1].d}, 32'h001);
            chk("b2b flags", {26'b0, got[0].p, got[0].f, got[0].b, got[1].p, got[1].f, got[1].b}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
